// File: rtl/micro_seq_pkg.sv
// Shared types and constants for the micro-sequencer: FSM state encoding,
// supported opcodes, datapath register codes and the step-table record.
package micro_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STEP1 = 3'd1,
        S_STEP2 = 3'd2,
        S_STEP3 = 3'd3,
        S_ADV   = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    localparam logic [7:0] OP_PUSH_EBP = 8'h55;
    localparam logic [7:0] OP_MOV      = 8'h89;
    localparam logic [7:0] OP_MOV_EAX  = 8'hb8;
    localparam logic [7:0] OP_POP_EBP  = 8'h5d;
    localparam logic [7:0] OP_RET      = 8'hc3;
    localparam logic [7:0] OP_LOOP     = 8'he2;
    localparam logic [7:0] OP_PUSH_IMM = 8'h6a;

    localparam logic [3:0] REG_ESP = 4'd1;
    localparam logic [3:0] REG_EBP = 4'd2;
    localparam logic [3:0] REG_EAX = 4'd3;
    localparam logic [3:0] REG_EIP = 4'd4;

    typedef struct packed {
        logic       legal;
        logic [1:0] n_steps;
        logic       eip_write;
    } step_info_t;

endpackage

// File: rtl/micro_sequencer_if.sv
// Fetch/decode and datapath signals of the micro-sequencer; the sequencer is
// the slave side, fetch/decode plus register file/ALU form the master side.
interface micro_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic             instr_ready;
    logic [7:0]       opcode;
    logic [3:0]       reg_load_1;
    logic [3:0]       reg_load_2;
    logic [3:0]       reg_load_3;
    logic [3:0]       select_1;
    logic [3:0]       select_2;
    logic [3:0]       select_3;
    logic [3:0]       num_of_ope;
    logic             stall;
    logic [3:0]       alu_sel;
    logic [3:0]       load_sel;
    logic             load_we;
    logic             eip_adv;
    logic [3:0]       eip_inc;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output instr_valid, opcode, reg_load_1, reg_load_2, reg_load_3,
               select_1, select_2, select_3, num_of_ope, stall,
        input  instr_ready, alu_sel, load_sel, load_we, eip_adv, eip_inc,
               halted, instr_count
    );

    modport slave (
        input  instr_valid, opcode, reg_load_1, reg_load_2, reg_load_3,
               select_1, select_2, select_3, num_of_ope, stall,
        output instr_ready, alu_sel, load_sel, load_we, eip_adv, eip_inc,
               halted, instr_count
    );
endinterface

// File: rtl/micro_step_table.sv
// Opcode lookup: number of ALU micro-steps and whether the instruction writes
// eip itself (in which case the sequencer must not advance it).
module micro_step_table
    import micro_seq_pkg::*;
(
    input  logic [7:0] opcode,
    output step_info_t info
);
    always_comb begin
        info = '{legal: 1'b0, n_steps: 2'd0, eip_write: 1'b0};
        case (opcode)
            OP_PUSH_EBP: info = '{legal: 1'b1, n_steps: 2'd2, eip_write: 1'b0};
            OP_MOV:      info = '{legal: 1'b1, n_steps: 2'd1, eip_write: 1'b0};
            OP_MOV_EAX:  info = '{legal: 1'b1, n_steps: 2'd1, eip_write: 1'b0};
            OP_POP_EBP:  info = '{legal: 1'b1, n_steps: 2'd2, eip_write: 1'b0};
            OP_RET:      info = '{legal: 1'b1, n_steps: 2'd2, eip_write: 1'b1};
            OP_LOOP:     info = '{legal: 1'b1, n_steps: 2'd3, eip_write: 1'b1};
            // eip_write entry of 2 collapses to 0 in the one-bit field: push imm advances eip
            OP_PUSH_IMM: info = '{legal: 1'b1, n_steps: 2'd2, eip_write: 1'b0};
            default:     ;
        endcase
    end
endmodule

// File: rtl/micro_sequencer.sv
// Steps each accepted instruction through its ALU micro-steps, then issues the
// eip advance and counts it as retired. Unknown opcodes trap in S_HALT.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk2,
    input  logic             reset,
    micro_sequencer_if.slave bus
);
    state_t           state_reg, state_next;
    step_info_t       info;
    logic [1:0]       n_steps_reg;
    logic             eip_write_reg;
    logic [3:0]       sel_reg  [3];
    logic [3:0]       load_reg [3];
    logic [3:0]       sel_in   [3];
    logic [3:0]       load_in  [3];
    logic [3:0]       num_reg;
    logic             num_taken_reg;
    logic [3:0]       eip_inc_reg;
    logic [CNT_W-1:0] count_reg;
    logic             accept;
    logic [1:0]       step_idx;

    logic [3:0]       alu_sel_next, load_sel_next;
    logic             load_we_next, eip_adv_next, ready_next, halted_next;

    micro_step_table u_table (
        .opcode (bus.opcode),
        .info   (info)
    );

    assign sel_in[0]  = bus.select_1;
    assign sel_in[1]  = bus.select_2;
    assign sel_in[2]  = bus.select_3;
    assign load_in[0] = bus.reg_load_1;
    assign load_in[1] = bus.reg_load_2;
    assign load_in[2] = bus.reg_load_3;

    assign accept   = (state_reg == S_IDLE) && bus.instr_valid;
    assign step_idx = (state_reg == S_STEP1) ? 2'd0 :
                      (state_reg == S_STEP2) ? 2'd1 : 2'd2;

    always_comb begin
        state_next    = state_reg;
        alu_sel_next  = 4'd0;
        load_sel_next = 4'd0;
        load_we_next  = 1'b0;
        eip_adv_next  = 1'b0;
        ready_next    = 1'b0;
        halted_next   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                ready_next = 1'b1;
                if (bus.instr_valid)
                    state_next = info.legal ? S_STEP1 : S_HALT;
            end
            S_STEP1, S_STEP2, S_STEP3: begin
                alu_sel_next  = sel_reg[step_idx];
                load_sel_next = load_reg[step_idx];
                load_we_next  = !bus.stall;
                if (!bus.stall) begin
                    if (step_idx + 2'd1 == n_steps_reg)
                        state_next = S_ADV;
                    else
                        state_next = (state_reg == S_STEP1) ? S_STEP2 : S_STEP3;
                end
            end
            S_ADV: begin
                eip_adv_next = !eip_write_reg;
                state_next   = S_IDLE;
            end
            S_HALT:  halted_next = 1'b1;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            n_steps_reg   <= 2'd0;
            eip_write_reg <= 1'b0;
            num_reg       <= 4'd0;
            num_taken_reg <= 1'b0;
            eip_inc_reg   <= 4'd0;
            count_reg     <= '0;
            for (int i = 0; i < 3; i++) begin
                sel_reg[i]  <= 4'd0;
                load_reg[i] <= 4'd0;
            end
        end else begin
            state_reg <= state_next;
            if (accept) begin
                n_steps_reg   <= info.n_steps;
                eip_write_reg <= info.eip_write;
                num_taken_reg <= 1'b0;
                for (int i = 0; i < 3; i++) begin
                    sel_reg[i]  <= sel_in[i];
                    load_reg[i] <= load_in[i];
                end
            end
            // decode delivers num_of_ope one cycle late; capture it once, stalled or not
            if (state_reg == S_STEP1 && !num_taken_reg) begin
                num_reg       <= bus.num_of_ope;
                num_taken_reg <= 1'b1;
            end
            if (state_next == S_ADV) begin
                count_reg <= count_reg + CNT_W'(1);
                if (!eip_write_reg)
                    eip_inc_reg <= num_taken_reg ? num_reg : bus.num_of_ope;
            end
        end
    end

    assign bus.instr_ready = ready_next;
    assign bus.alu_sel     = alu_sel_next;
    assign bus.load_sel    = load_sel_next;
    assign bus.load_we     = load_we_next;
    assign bus.eip_adv     = eip_adv_next;
    assign bus.eip_inc     = eip_inc_reg;
    assign bus.halted      = halted_next;
    assign bus.instr_count = count_reg;
endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench: directed and random instructions compared cycle by
// cycle against an expected trace built from the opcode step table.
module tb_micro_sequencer;
    localparam int CNT_W = 4;

    logic clk2 = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [CNT_W-1:0] count_exp = '0;
    logic [3:0]       eip_inc_exp = 4'd0;
    logic [7:0]       ops [7] = '{8'h55, 8'h89, 8'hb8, 8'h5d, 8'hc3, 8'he2, 8'h6a};

    micro_sequencer_if #(.CNT_W(CNT_W)) bus ();

    micro_sequencer #(.CNT_W(CNT_W)) dut (
        .clk2  (clk2),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk2 = ~clk2;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // opcode -> {legal, steps, writes eip}
    task automatic ref_table(input logic [7:0] op, output bit legal, output int n, output bit ew);
        legal = 1'b1; ew = 1'b0;
        case (op)
            8'h55, 8'h5d, 8'h6a: n = 2;
            8'h89, 8'hb8:        n = 1;
            8'hc3:     begin n = 2; ew = 1'b1; end
            8'he2:     begin n = 3; ew = 1'b1; end
            default:   begin n = 0; legal = 1'b0; end
        endcase
    endtask

    task automatic check_outs(input string tag, input bit rdy, input logic [3:0] alu,
                              input logic [3:0] ld, input bit we, input bit adv, input bit hlt);
        chk({tag, ".ready"},  bus.instr_ready, rdy);
        chk({tag, ".alu"},    bus.alu_sel, alu);
        chk({tag, ".load"},   bus.load_sel, ld);
        chk({tag, ".we"},     bus.load_we, we);
        chk({tag, ".adv"},    bus.eip_adv, adv);
        chk({tag, ".halted"}, bus.halted, hlt);
        chk({tag, ".inc"},    bus.eip_inc, eip_inc_exp);
        chk({tag, ".count"},  bus.instr_count, count_exp);
    endtask

    task automatic expect_cycle(input string tag, input bit rdy, input logic [3:0] alu,
                                input logic [3:0] ld, input bit we, input bit adv, input bit hlt);
        @(negedge clk2);
        check_outs(tag, rdy, alu, ld, we, adv, hlt);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.stall = 1'b0;
        #1;
        count_exp = '0;
        eip_inc_exp = 4'd0;
        check_outs("reset", 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk2);
        @(negedge clk2);
        reset = 1'b0;
    endtask

    task automatic scramble();
        bus.opcode     = 8'($urandom);
        bus.select_1   = 4'($urandom);
        bus.select_2   = 4'($urandom);
        bus.select_3   = 4'($urandom);
        bus.reg_load_1 = 4'($urandom);
        bus.reg_load_2 = 4'($urandom);
        bus.reg_load_3 = 4'($urandom);
    endtask

    task automatic run_instr(input logic [7:0] op,
                             input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] s3,
                             input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] r3,
                             input logic [3:0] num, input int st1, input int st2, input int st3);
        bit legal, ew;
        int n;
        logic [3:0] sv [3];
        logic [3:0] rv [3];
        int st [3];
        sv = '{s1, s2, s3};
        rv = '{r1, r2, r3};
        st = '{st1, st2, st3};
        ref_table(op, legal, n, ew);
        bus.instr_valid = 1'b1;
        bus.opcode = op;
        bus.select_1 = s1; bus.select_2 = s2; bus.select_3 = s3;
        bus.reg_load_1 = r1; bus.reg_load_2 = r2; bus.reg_load_3 = r3;
        bus.num_of_ope = 4'($urandom);
        bus.stall = 1'b0;
        @(posedge clk2); #1;
        scramble();
        bus.instr_valid = 1'($urandom);
        bus.num_of_ope = num;
        if (!legal) begin
            for (int c = 0; c < 20; c++) begin
                bus.stall = 1'($urandom);
                expect_cycle("halt", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
                @(posedge clk2); #1;
                bus.instr_valid = 1'($urandom);
            end
            bus.instr_valid = 1'b0;
            $display("instr op=%02h illegal halted count=%0d", op, count_exp);
            return;
        end
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c <= st[k]; c++) begin
                bus.stall = (c < st[k]);
                expect_cycle($sformatf("step%0d", k + 1), 1'b0, sv[k], rv[k], !(c < st[k]), 1'b0, 1'b0);
                @(posedge clk2); #1;
                bus.num_of_ope = 4'($urandom);
                bus.instr_valid = 1'($urandom);
                scramble();
            end
        end
        bus.stall = 1'($urandom);
        count_exp = count_exp + 1'b1;
        if (!ew) eip_inc_exp = num;
        expect_cycle("adv", 1'b0, 4'd0, 4'd0, 1'b0, !ew, 1'b0);
        @(posedge clk2); #1;
        bus.stall = 1'b0;
        bus.instr_valid = 1'b0;
        expect_cycle("idle", 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        $display("instr op=%02h steps=%0d stalls=%0d/%0d/%0d inc=%0d count=%0d",
                 op, n, st1, st2, st3, eip_inc_exp, count_exp);
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.stall = 1'b0;
        bus.num_of_ope = 4'd0;
        scramble();
        @(negedge clk2);
        do_reset();

        // reset in the middle of step2 of pop ebp
        bus.instr_valid = 1'b1;
        bus.opcode = 8'h5d;
        bus.select_1 = 4'd3; bus.reg_load_1 = 4'd1;
        bus.select_2 = 4'd5; bus.reg_load_2 = 4'd2;
        @(posedge clk2); #1;
        bus.instr_valid = 1'b0;
        bus.num_of_ope = 4'd1;
        expect_cycle("abort.step1", 1'b0, 4'd3, 4'd1, 1'b1, 1'b0, 1'b0);
        @(posedge clk2); #1;
        expect_cycle("abort.step2", 1'b0, 4'd5, 4'd2, 1'b1, 1'b0, 1'b0);
        do_reset();
        $display("instr op=5d aborted by reset count=%0d", count_exp);

        run_instr(8'h89, 4'd2, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 4'd2, 0, 0, 0);
        run_instr(8'he2, 4'd2, 4'd3, 4'd2, 4'd1, 4'd1, 4'd4, 4'd5, 0, 0, 0);
        run_instr(8'h55, 4'd2, 4'd7, 4'd0, 4'd1, 4'd1, 4'd0, 4'd1, 3, 0, 0);
        run_instr(8'hc3, 4'd6, 4'd4, 4'd0, 4'd1, 4'd4, 4'd0, 4'd3, 0, 2, 0);
        run_instr(8'h6a, 4'd9, 4'd1, 4'd0, 4'd1, 4'd1, 4'd0, 4'd2, 1, 1, 0);

        run_instr(8'hff, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 0, 0, 0);
        do_reset();

        // counter wrap with back-to-back single-step instructions
        for (int i = 0; i < 17; i++)
            run_instr(8'hb8, 4'($urandom), 4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'($urandom), 0, 0, 0);

        for (int i = 0; i < 40; i++)
            run_instr(ops[$urandom_range(0, 6)],
                      4'($urandom), 4'($urandom), 4'($urandom),
                      4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));

        run_instr(8'h00, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 0, 0, 0);
        do_reset();
        run_instr(8'h89, 4'd4, 4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd6, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Sequences each decoded instruction through its 1–3 ALU micro-steps, one step per clk2 cycle.
- Drives the ALU input-select code, the destination-register code and the write strobe to the register/ALU datapath.
- Issues the eip advance strobe after the last step; handshakes with fetch for the next instruction.
- Sits between fetch/decode and the register file/ALU. Halts on an unknown opcode.

Parameters:
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk2  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- instr_valid  in  1  fetch presents a new instruction on opcode and the decode step fields.
- instr_ready  out  1  sequencer accepts an instruction this cycle.
- opcode  in  8  first opcode byte of the instruction (ope[31:24]).
- reg_load_1, reg_load_2, reg_load_3  in  4 each  decoded destination code per step.
- select_1, select_2, select_3  in  4 each  decoded ALU input-select code per step.
- num_of_ope  in  4  decoded eip increment; registered by decode on clk2.
- stall  in  1  datapath/memory wait; freezes the current step.
- alu_sel  out  4  ALU input-select code for the current step.
- load_sel  out  4  destination register code for the current step.
- load_we  out  1  register write strobe.
- eip_adv  out  1  eip += eip_inc strobe.
- eip_inc  out  4  increment value.
- halted  out  1  illegal opcode trapped.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset (asynchronous): state=S_IDLE; instr_ready=1; alu_sel=0, load_sel=0, load_we=0, eip_adv=0, eip_inc=0, halted=0, instr_count=0. Reset mid-instruction aborts it with no further strobes.
- States: S_IDLE, S_STEP1, S_STEP2, S_STEP3, S_ADV, S_HALT.
- instr_ready=1 only in S_IDLE.
- Accept: instr_valid && instr_ready at a clk2 edge. At that edge, latch opcode, all six step fields, n_steps and eip_write from the step table.
- Step table (opcode -> n_steps, eip_write):
  - 55 -> 2,0
  - 89 -> 1,0
  - b8 -> 1,0
  - 5d -> 2,0
  - c3 -> 2,1
  - e2 -> 3,1
  - 6a -> 2,2
  - Any other opcode -> illegal.
- Illegal accept: next state S_HALT; halted=1; instr_ready=0; no strobes. Exit only by reset.
- S_STEPk: alu_sel=select_k and load_sel=reg_load_k (latched copies); load_we = !stall.
  - stall=1: hold state and outputs.
  - stall=0: go to S_STEP(k+1) if k<n_steps, else S_ADV.
- num_of_ope: latched at the first clk2 edge spent in S_STEP1, whether or not stall is asserted (one-bit flag). Decode registers it one cycle after the opcode is presented.
- S_ADV (one cycle, not stallable):
  - eip_write=0: eip_adv=1, eip_inc=latched num_of_ope.
  - eip_write=1: eip_adv=0 (instruction wrote eip itself).
  - Always: instr_count += 1, wraps modulo 2^CNT_W. Next state S_IDLE.
- Outside S_STEPk, load_we=0 and alu_sel/load_sel=0. Outside S_ADV, eip_adv=0. eip_inc holds its last value.
- Latency, no stall: accept at edge T; step1 in cycle T+1; last step in cycle T+n; S_ADV in cycle T+n+1; instr_ready again in cycle T+n+2. Throughput is one instruction per n+2 cycles.
- Decoded x values in unused step fields are never driven out: steps beyond n_steps are not entered.
- instr_valid while not in S_IDLE: ignored. Fetch holds the instruction until accepted.

Decomposition:
- Package micro_seq_pkg:
  - state encoding;
  - opcode constants (OP_PUSH_EBP=55, OP_MOV=89, OP_MOV_EAX=b8, OP_POP_EBP=5d, OP_RET=c3, OP_LOOP=e2, OP_PUSH_IMM=6a);
  - register codes ESP=1, EBP=2, EAX=3, EIP=4.
- Sub-module micro_step_table: combinational opcode -> {legal, n_steps[1:0], eip_write}.

Test Plan:
- Reset, then opcode 89 with select_1=2, reg_load_1=2, num_of_ope=2:
  - cycle T+1: alu_sel=2, load_sel=2, load_we=1;
  - cycle T+2: eip_adv=1, eip_inc=2, instr_count=1;
  - cycle T+3: instr_ready=1.
- opcode e2 (loop), three steps:
  - load_sel sequence 1,1,4 and alu_sel 2,3,2 on T+1..T+3;
  - S_ADV at T+4 with eip_adv=0; instr_count increments.
- opcode 55 with stall=1 for 3 cycles during step1:
  - alu_sel=2/load_sel=1 held, load_we=0 while stalled;
  - step2 follows the first unstalled cycle;
  - eip_inc=1 (num_of_ope latched at first S_STEP1 edge, unchanged by later decode updates).
- opcode 0xFF: halted=1 from T+1, instr_ready=0, no load_we/eip_adv for 20 cycles; reset clears halted and returns instr_ready=1.
- Reset asserted during step2 of 5d: all strobes drop immediately (asynchronously), instr_count unchanged at 0.
- CNT_W=4, 17 back-to-back b8 instructions: instr_count wraps 15 -> 0 -> 1; each instruction spans exactly 3 cycles.
